// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : RV32I opcode map, ALU operation enum, control-bit layout and
//             the registered decode beat shared by the decode stage.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN_C = 32;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_e;

    // ctrl byte layout: {is_load,is_store,is_branch,is_jal,is_jalr,is_lui,is_auipc,alu_src_imm}
    localparam int CTRL_LOAD    = 7;
    localparam int CTRL_STORE   = 6;
    localparam int CTRL_BRANCH  = 5;
    localparam int CTRL_JAL     = 4;
    localparam int CTRL_JALR    = 3;
    localparam int CTRL_LUI     = 2;
    localparam int CTRL_AUIPC   = 1;
    localparam int CTRL_SRC_IMM = 0;

    typedef struct packed {
        logic [XLEN_C-1:0] pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN_C-1:0] rs1data;
        logic [XLEN_C-1:0] rs2data;
        logic [XLEN_C-1:0] imm;
        logic [2:0]        funct3;
        logic [3:0]        aluop;
        logic [7:0]        ctrl;
        logic              illegal;
    } dec_beat_t;

    // alt selects SUB/SRA (inst[30]) for the funct3 codes that have an alternate form
    function automatic aluop_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        aluop_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idec_core.sv
`default_nettype none
// ============================================================================
//  Module   : idec_core
//  Brief    : Pure combinational RV32I instruction decoder: immediate, ALU op,
//             control flags, operand usage and legality.
//  Revision : 1.0  initial release
// ============================================================================
module idec_core
    import rv32i_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o,
    output logic [3:0]  aluop_o,
    output logic [7:0]  ctrl_o,
    output logic        has_rd_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i_w;
    logic [31:0] imm_s_w;
    logic [31:0] imm_b_w;
    logic [31:0] imm_u_w;
    logic [31:0] imm_j_w;

    assign opcode  = inst_i[6:0];
    assign f3      = inst_i[14:12];
    assign f7      = inst_i[31:25];

    assign imm_i_w = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_w = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_w = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_w = {inst_i[31:12], 12'b0};
    assign imm_j_w = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign uses_rs1_o = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2_o = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    always_comb begin
        imm_o     = '0;
        aluop_o   = ALU_ADD;
        ctrl_o    = '0;
        has_rd_o  = 1'b0;
        illegal_o = 1'b0;

        case (opcode)
            OP_LOAD: begin
                imm_o                = imm_i_w;
                ctrl_o[CTRL_LOAD]    = 1'b1;
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
                has_rd_o             = 1'b1;
            end
            OP_STORE: begin
                imm_o                = imm_s_w;
                ctrl_o[CTRL_STORE]   = 1'b1;
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
            end
            OP_BRANCH: begin
                // BEQ/BNE compare by subtraction, the rest by signed/unsigned less-than
                imm_o               = imm_b_w;
                ctrl_o[CTRL_BRANCH] = 1'b1;
                aluop_o             = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OP_JAL: begin
                imm_o            = imm_j_w;
                ctrl_o[CTRL_JAL] = 1'b1;
                has_rd_o         = 1'b1;
            end
            OP_JALR: begin
                imm_o                = imm_i_w;
                ctrl_o[CTRL_JALR]    = 1'b1;
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
                has_rd_o             = 1'b1;
            end
            OP_LUI: begin
                imm_o                = imm_u_w;
                aluop_o              = ALU_PASSB;
                ctrl_o[CTRL_LUI]     = 1'b1;
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
                has_rd_o             = 1'b1;
            end
            OP_AUIPC: begin
                imm_o                = imm_u_w;
                ctrl_o[CTRL_AUIPC]   = 1'b1;
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
                has_rd_o             = 1'b1;
            end
            OP_IMM: begin
                imm_o                = imm_i_w;
                aluop_o              = alu_from_funct3(f3, (f3 == 3'b101) && inst_i[30]);
                ctrl_o[CTRL_SRC_IMM] = 1'b1;
                has_rd_o             = 1'b1;
                if ((f3 == 3'b001 && f7 != F7_BASE) ||
                    (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT))
                    illegal_o = 1'b1;
            end
            OP_OP: begin
                aluop_o  = alu_from_funct3(f3, inst_i[30]);
                has_rd_o = 1'b1;
                if (f7 != F7_BASE && f7 != F7_ALT)
                    illegal_o = 1'b1;
                else if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101)
                    illegal_o = 1'b1;
            end
            OP_MISC_MEM, OP_SYSTEM: begin
                imm_o = imm_i_w;
            end
            default: illegal_o = 1'b1;
        endcase

        if (illegal_o) begin
            imm_o    = '0;
            aluop_o  = ALU_ADD;
            ctrl_o   = '0;
            has_rd_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/idec.sv
`default_nettype none
// ============================================================================
//  Module   : idec
//  Brief    : RV32I decode stage: fetch handshake, load-use interlock, jump
//             flush and the registered decode beat towards execute.
//  Revision : 1.0  initial release
// ============================================================================
module idec
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic [4:0]      rs1addr_o,
    output logic [4:0]      rs2addr_o,
    input  logic [XLEN-1:0] rs1data_i,
    input  logic [XLEN-1:0] rs2data_i,
    output logic            valid_ro,
    input  logic            ready_i,
    input  logic            jump_taken_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [4:0]      rd_ro,
    output logic [4:0]      rs1_ro,
    output logic [4:0]      rs2_ro,
    output logic [XLEN-1:0] rs1data_ro,
    output logic [XLEN-1:0] rs2data_ro,
    output logic [XLEN-1:0] imm_ro,
    output logic [2:0]      funct3_ro,
    output logic [3:0]      aluop_ro,
    output logic [7:0]      ctrl_ro,
    output logic            illegal_ro
);

    logic [31:0] dec_imm;
    logic [3:0]  dec_aluop;
    logic [7:0]  dec_ctrl;
    logic        dec_has_rd;
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic        dec_illegal;

    logic        cke;
    logic        hazard;
    logic        valid_q;
    logic        valid_d;
    dec_beat_t   beat_q;
    dec_beat_t   beat_d;

    idec_core u_core (
        .inst_i     (inst_i),
        .imm_o      (dec_imm),
        .aluop_o    (dec_aluop),
        .ctrl_o     (dec_ctrl),
        .has_rd_o   (dec_has_rd),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2),
        .illegal_o  (dec_illegal)
    );

    assign rs1addr_o = inst_i[19:15];
    assign rs2addr_o = inst_i[24:20];

    assign cke = ~valid_q | ready_i | jump_taken_i;

    generate
        if (HAZARD_EN) begin : g_hazard
            // only the beat directly behind a load needs the bubble; later ones are forwarded
            assign hazard = valid_i & valid_q & beat_q.ctrl[CTRL_LOAD] & (beat_q.rd != 5'd0) &
                            ((dec_uses_rs1 & (beat_q.rd == inst_i[19:15])) |
                             (dec_uses_rs2 & (beat_q.rd == inst_i[24:20])));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    assign ready_o = cke & ~(hazard & ~jump_taken_i);

    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (cke) begin
            if (jump_taken_i || hazard) begin
                valid_d = 1'b0;
            end else begin
                valid_d        = valid_i;
                beat_d.pc      = pc_i;
                beat_d.rd      = dec_has_rd ? inst_i[11:7] : 5'd0;
                beat_d.rs1     = inst_i[19:15];
                beat_d.rs2     = inst_i[24:20];
                beat_d.rs1data = rs1data_i;
                beat_d.rs2data = rs2data_i;
                beat_d.imm     = dec_imm;
                beat_d.funct3  = inst_i[14:12];
                beat_d.aluop   = dec_aluop;
                beat_d.ctrl    = dec_ctrl;
                beat_d.illegal = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign valid_ro   = valid_q;
    assign pc_ro      = beat_q.pc;
    assign rd_ro      = beat_q.rd;
    assign rs1_ro     = beat_q.rs1;
    assign rs2_ro     = beat_q.rs2;
    assign rs1data_ro = beat_q.rs1data;
    assign rs2data_ro = beat_q.rs2data;
    assign imm_ro     = beat_q.imm;
    assign funct3_ro  = beat_q.funct3;
    assign aluop_ro   = beat_q.aluop;
    assign ctrl_ro    = beat_q.ctrl;
    assign illegal_ro = beat_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_idec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idec
//  Brief    : Directed self-checking bench for the idec decode stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_idec;
    import rv32i_pkg::*;

    localparam logic [31:0] I_ADDI  = 32'hFFB10093; // addi x1,x2,-5
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD   = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] I_ADD0  = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] I_LUI5  = 32'h0002B2B7; // lui  x5,0x2B (rs1 field = 5)
    localparam logic [31:0] I_JAL   = 32'h001000EF; // jal  x1,+2048

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [4:0]  rs1addr_o;
    logic [4:0]  rs2addr_o;
    logic [31:0] rs1data_i;
    logic [31:0] rs2data_i;
    logic        valid_ro;
    logic        ready_i;
    logic        jump_taken_i;
    logic [31:0] pc_ro;
    logic [4:0]  rd_ro;
    logic [4:0]  rs1_ro;
    logic [4:0]  rs2_ro;
    logic [31:0] rs1data_ro;
    logic [31:0] rs2data_ro;
    logic [31:0] imm_ro;
    logic [2:0]  funct3_ro;
    logic [3:0]  aluop_ro;
    logic [7:0]  ctrl_ro;
    logic        illegal_ro;

    logic [31:0] salt;
    int          n_checks;
    int          n_fail;

    // regfile model: read data is a salted copy of the address
    assign rs1data_i = salt ^ {27'd0, rs1addr_o};
    assign rs2data_i = ~salt ^ {27'd0, rs2addr_o};

    idec #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .rs1addr_o    (rs1addr_o),
        .rs2addr_o    (rs2addr_o),
        .rs1data_i    (rs1data_i),
        .rs2data_i    (rs2data_i),
        .valid_ro     (valid_ro),
        .ready_i      (ready_i),
        .jump_taken_i (jump_taken_i),
        .pc_ro        (pc_ro),
        .rd_ro        (rd_ro),
        .rs1_ro       (rs1_ro),
        .rs2_ro       (rs2_ro),
        .rs1data_ro   (rs1data_ro),
        .rs2data_ro   (rs2data_ro),
        .imm_ro       (imm_ro),
        .funct3_ro    (funct3_ro),
        .aluop_ro     (aluop_ro),
        .ctrl_ro      (ctrl_ro),
        .illegal_ro   (illegal_ro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        valid_i = v;
        pc_i    = pc;
        inst_i  = inst;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", valid_ro); end
        n_checks++; if (pc_ro !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_ro); end
        n_checks++; if (imm_ro !== 32'h0 || ctrl_ro !== 8'h0 || rd_ro !== 5'd0 || illegal_ro !== 1'b0) begin
            n_fail++; $display("FAIL reset_fields: imm %h ctrl %h rd %0d ill %0h want all 0", imm_ro, ctrl_ro, rd_ro, illegal_ro); end
        rst     = 1'b1;
        ready_i = 1'b1;
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %0h want 0", valid_ro); end
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h100, I_ADDI);
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", valid_ro); end
        n_checks++; if (pc_ro !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h want 00000100", pc_ro); end
        n_checks++; if (rd_ro !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", rd_ro); end
        n_checks++; if (imm_ro !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_imm: got %h want fffffffb", imm_ro); end
        n_checks++; if (aluop_ro !== ALU_ADD) begin n_fail++; $display("FAIL addi_aluop: got %0d want %0d", aluop_ro, ALU_ADD); end
        n_checks++; if (ctrl_ro !== 8'h01) begin n_fail++; $display("FAIL addi_ctrl: got %h want 01", ctrl_ro); end
        n_checks++; if (rs1_ro !== 5'd2 || rs1data_ro !== (salt ^ 32'd2)) begin
            n_fail++; $display("FAIL addi_rs1: got x%0d %h want x2 %h", rs1_ro, rs1data_ro, salt ^ 32'd2); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h want 0", valid_ro); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h200, I_LW5);
        tick();
        n_checks++; if (valid_ro !== 1'b1 || rd_ro !== 5'd5 || ctrl_ro !== 8'h81) begin
            n_fail++; $display("FAIL lu_load: valid %0h rd %0d ctrl %h want 1 5 81", valid_ro, rd_ro, ctrl_ro); end
        drive(1'b1, 32'h204, I_ADD);
        #1;
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL lu_hold: ready_o %0h want 0", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: valid %0h want 0", valid_ro); end
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL lu_release: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h204 || rs1_ro !== 5'd5 || rs2_ro !== 5'd7 || rd_ro !== 5'd6) begin
            n_fail++; $display("FAIL lu_add: valid %0h pc %h rs1 %0d rs2 %0d rd %0d want 1 204 5 7 6", valid_ro, pc_ro, rs1_ro, rs2_ro, rd_ro); end
        n_checks++; if (rs2data_ro !== (~salt ^ 32'd7) || ctrl_ro !== 8'h00) begin
            n_fail++; $display("FAIL lu_add_data: rs2data %h ctrl %h want %h 00", rs2data_ro, ctrl_ro, ~salt ^ 32'd7); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL lu_drain: valid %0h want 0", valid_ro); end
    endtask

    task automatic test_no_bubble();
        drive(1'b1, 32'h300, I_LW0);
        tick();
        drive(1'b1, 32'h304, I_ADD0);
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL nb_x0_ready: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h304) begin
            n_fail++; $display("FAIL nb_x0_beat: valid %0h pc %h want 1 304", valid_ro, pc_ro); end
        drive(1'b1, 32'h308, I_LW5);
        tick();
        drive(1'b1, 32'h30C, I_LUI5);
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL nb_lui_ready: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h30C || rd_ro !== 5'd5) begin
            n_fail++; $display("FAIL nb_lui_beat: valid %0h pc %h rd %0d want 1 30c 5", valid_ro, pc_ro, rd_ro); end
        n_checks++; if (imm_ro !== 32'h0002B000 || aluop_ro !== ALU_PASSB || ctrl_ro !== 8'h05) begin
            n_fail++; $display("FAIL nb_lui_dec: imm %h alu %0d ctrl %h want 0002b000 %0d 05", imm_ro, aluop_ro, ctrl_ro, ALU_PASSB); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] old_salt;
        drive(1'b1, 32'h400, I_ADDI);
        tick();
        old_salt = salt;
        ready_i  = 1'b0;
        drive(1'b1, 32'h404, I_JAL);
        salt     = 32'h0F0F1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: ready_o %0h want 0", i, ready_o); end
            tick();
            n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h400 || imm_ro !== 32'hFFFFFFFB || rs1data_ro !== (old_salt ^ 32'd2)) begin
                n_fail++; $display("FAIL stall_hold[%0d]: valid %0h pc %h imm %h rs1data %h want 1 400 fffffffb %h",
                                   i, valid_ro, pc_ro, imm_ro, rs1data_ro, old_salt ^ 32'd2); end
        end
        ready_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h404 || imm_ro !== 32'h00000800 || ctrl_ro !== 8'h10 || rd_ro !== 5'd1) begin
            n_fail++; $display("FAIL stall_jal: valid %0h pc %h imm %h ctrl %h rd %0d want 1 404 00000800 10 1",
                               valid_ro, pc_ro, imm_ro, ctrl_ro, rd_ro); end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL stall_once: valid %0h want 0", valid_ro); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h500, I_LW5);
        tick();
        drive(1'b1, 32'h504, I_ADD);
        jump_taken_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_hz_ready: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL flush_hz_valid: valid %0h want 0", valid_ro); end
        jump_taken_i = 1'b0;
        drive(1'b1, 32'h510, I_ADDI);
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h510) begin
            n_fail++; $display("FAIL flush_pre: valid %0h pc %h want 1 510", valid_ro, pc_ro); end
        ready_i = 1'b0;
        drive(1'b1, 32'h514, I_ADD);
        #1;
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_ready: ready_o %0h want 0", ready_o); end
        jump_taken_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_st_ready: ready_o %0h want 1", ready_o); end
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL flush_st_valid: valid %0h want 0", valid_ro); end
        jump_taken_i = 1'b0;
        ready_i      = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: valid %0h want 0", valid_ro); end
    endtask

    logic [31:0] t_inst [0:6];
    logic [31:0] t_imm  [0:6];
    logic [7:0]  t_ctrl [0:6];
    logic [4:0]  t_rd   [0:6];
    logic        t_ill  [0:6];
    logic        t_cimm [0:6];
    logic        t_calu [0:6];
    logic [3:0]  t_alu  [0:6];

    task automatic test_decode();
        t_inst[0] = 32'h00000000; t_imm[0] = 32'h0;        t_ctrl[0] = 8'h00; t_rd[0] = 5'd0; t_ill[0] = 1'b1; t_cimm[0] = 1'b0; t_calu[0] = 1'b0; t_alu[0] = ALU_ADD;
        t_inst[1] = 32'h80208063; t_imm[1] = 32'hFFFFF000; t_ctrl[1] = 8'h20; t_rd[1] = 5'd0; t_ill[1] = 1'b0; t_cimm[1] = 1'b1; t_calu[1] = 1'b0; t_alu[1] = ALU_ADD;
        t_inst[2] = 32'hFE20AC23; t_imm[2] = 32'hFFFFFFF8; t_ctrl[2] = 8'h41; t_rd[2] = 5'd0; t_ill[2] = 1'b0; t_cimm[2] = 1'b1; t_calu[2] = 1'b1; t_alu[2] = ALU_ADD;
        t_inst[3] = 32'h402091B3; t_imm[3] = 32'h0;        t_ctrl[3] = 8'h00; t_rd[3] = 5'd0; t_ill[3] = 1'b1; t_cimm[3] = 1'b0; t_calu[3] = 1'b0; t_alu[3] = ALU_ADD;
        t_inst[4] = 32'h4040D193; t_imm[4] = 32'h00000404; t_ctrl[4] = 8'h01; t_rd[4] = 5'd3; t_ill[4] = 1'b0; t_cimm[4] = 1'b1; t_calu[4] = 1'b1; t_alu[4] = ALU_SRA;
        t_inst[5] = 32'h00000073; t_imm[5] = 32'h0;        t_ctrl[5] = 8'h00; t_rd[5] = 5'd0; t_ill[5] = 1'b0; t_cimm[5] = 1'b1; t_calu[5] = 1'b0; t_alu[5] = ALU_ADD;
        t_inst[6] = 32'h00A00090; t_imm[6] = 32'h0;        t_ctrl[6] = 8'h00; t_rd[6] = 5'd0; t_ill[6] = 1'b1; t_cimm[6] = 1'b0; t_calu[6] = 1'b0; t_alu[6] = ALU_ADD;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h600 + 32'(4 * k), t_inst[k]);
            tick();
            n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h600 + 32'(4 * k)) begin
                n_fail++; $display("FAIL dec[%0d]_beat: valid %0h pc %h want 1 %h", k, valid_ro, pc_ro, 32'h600 + 32'(4 * k)); end
            n_checks++; if (illegal_ro !== t_ill[k] || ctrl_ro !== t_ctrl[k] || rd_ro !== t_rd[k]) begin
                n_fail++; $display("FAIL dec[%0d]_ctrl: ill %0h ctrl %h rd %0d want %0h %h %0d",
                                   k, illegal_ro, ctrl_ro, rd_ro, t_ill[k], t_ctrl[k], t_rd[k]); end
            if (t_cimm[k]) begin
                n_checks++; if (imm_ro !== t_imm[k]) begin n_fail++; $display("FAIL dec[%0d]_imm: got %h want %h", k, imm_ro, t_imm[k]); end
            end
            if (t_calu[k]) begin
                n_checks++; if (aluop_ro !== t_alu[k]) begin n_fail++; $display("FAIL dec[%0d]_alu: got %0d want %0d", k, aluop_ro, t_alu[k]); end
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h700, I_ADDI);
        tick();
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_checks++; if (valid_ro !== 1'b1 || pc_ro !== 32'h700) begin
            n_fail++; $display("FAIL ar_stalled: valid %0h pc %h want 1 700", valid_ro, pc_ro); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (valid_ro !== 1'b0 || pc_ro !== 32'h0) begin
            n_fail++; $display("FAIL ar_immediate: valid %0h pc %h want 0 0", valid_ro, pc_ro); end
        #1 rst = 1'b1;
        ready_i = 1'b1;
        tick();
        n_checks++; if (valid_ro !== 1'b0) begin n_fail++; $display("FAIL ar_restart: valid %0h want 0", valid_ro); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        valid_i      = 1'b0;
        pc_i         = 32'h0;
        inst_i       = 32'h0;
        ready_i      = 1'b0;
        jump_taken_i = 1'b0;
        salt         = 32'h5A5A0000;
        test_reset();
        test_addi();
        test_load_use();
        test_no_bubble();
        test_stall();
        test_flush();
        test_decode();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire
